adder_clk_gate: RTL and testbench



---
 rtl/adder_clk_gate.sv | 90 +++++++++
 tb/tb_adder_clk_gate.sv | 129 ++++++++++++
 2 files changed

// File: rtl/adder_clk_gate.sv
// Registered WIDTH-bit adder (two-stage: operand capture, then sum) with clock enable CG.
// Build option ADDER_CLK_GATE_ICG_EN selects a latch-based clock gate; otherwise CG is a load enable.
module adder_clk_gate #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             carry_in,
  input  logic             CG,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out
);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [WIDTH:0]   sum_full_s;
  logic             load_en;
  logic             reg_clk;

`ifdef ADDER_CLK_GATE_ICG_EN
  logic en_lat;
  logic gclk;

  // Enable latch is transparent only while clk is low, so gclk cannot glitch during the high phase.
  always_latch begin
    if (!reset_b) begin
      en_lat <= 1'b0;
    end else if (!clk) begin
      en_lat <= CG;
    end
  end

  assign gclk    = clk & en_lat;
  assign reg_clk = gclk;
  assign load_en = 1'b1;
`else
  assign reg_clk = clk;
  assign load_en = CG;
`endif

  assign sum_full_s = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, c_q};

  // Next-state: capture operands and sum when enabled, otherwise hold every stage.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    if (load_en) begin
      a_d     = a_in;
      b_d     = b_in;
      c_d     = carry_in;
      sum_d   = sum_full_s[WIDTH-1:0];
      carry_d = sum_full_s[WIDTH];
    end else begin
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      sum_d   = sum_q;
      carry_d = carry_q;
    end
  end

  // Pipeline registers; async reset discards in-flight data and clears the outputs.
  always_ff @(posedge reg_clk or negedge reset_b) begin
    if (!reset_b) begin
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      c_q     <= 1'b0;
      sum_q   <= {WIDTH{1'b0}};
      carry_q <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  assign sum_out   = sum_q;
  assign carry_out = carry_q;

endmodule

// File: tb/tb_adder_clk_gate.sv
// Scoreboard bench for adder_clk_gate: stimulus queues expected results tagged with the
// enabled edge on which they must appear; a monitor pops and compares them.
module tb_adder_clk_gate;

  logic        clk = 1'b0;
  logic        reset_b;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        carry_in;
  logic        CG;
  logic [15:0] sum_out;
  logic        carry_out;

  typedef struct {
    logic [16:0] exp;
    int          due;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   ecount = 0;
  int   checks = 0;
  int   errors = 0;
  int   gclk_edges = 0;

  adder_clk_gate #(.WIDTH(16)) dut (
    .clk(clk), .reset_b(reset_b), .a_in(a_in), .b_in(b_in),
    .carry_in(carry_in), .CG(CG), .sum_out(sum_out), .carry_out(carry_out)
  );

  always #10 clk = ~clk;

`ifdef ADDER_CLK_GATE_ICG_EN
  always @(posedge dut.gclk) gclk_edges++;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: count enabled edges, then compare any result due on this edge.
  initial begin
    forever begin
      @(posedge clk);
      if (reset_b === 1'b1 && CG === 1'b1) ecount++;
      #1;
      while (exp_q.size() > 0 && exp_q[0].due <= ecount) begin
        chk(exp_q[0].name, {15'd0, carry_out, sum_out}, {15'd0, exp_q[0].exp});
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic drive_vec(input string name, input logic [15:0] a, input logic [15:0] b,
                           input logic c, input logic [16:0] exp);
    exp_t e;
    @(negedge clk);
    a_in = a; b_in = b; carry_in = c; CG = 1'b1;
    e.exp = exp; e.due = ecount + 2; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_b = 1'b0;
    CG      = 1'b0;
    #20;
    chk("reset_sum", {16'd0, sum_out}, 32'h0000_0000);
    chk("reset_carry", {31'd0, carry_out}, 32'd0);
    @(negedge clk);
    reset_b = 1'b1;
    run_cycles(3);
    chk("post_reset_idle", {15'd0, carry_out, sum_out}, 32'h0000_0000);

    drive_vec("basic_add", 16'hA5A5, 16'h5A5A, 1'b0, 17'h0FFFF);
    drive_vec("basic_stable", 16'hA5A5, 16'h5A5A, 1'b0, 17'h0FFFF);

    // Gate and change inputs in the same instant, clk low.
    @(negedge clk);
    CG = 1'b0; a_in = 16'h1707; b_in = 16'h2345; carry_in = 1'b0;
    gclk_edges = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (i % 100 == 99) chk("gated_hold", {15'd0, carry_out, sum_out}, 32'h0000_FFFF);
    end
`ifdef ADDER_CLK_GATE_ICG_EN
    chk("gclk_edges_gated", gclk_edges, 32'd0);
`endif
    chk("gated_pending", exp_q.size(), 32'd1);

    drive_vec("reenable", 16'h1707, 16'h2345, 1'b0, 17'h03A4C);
    drive_vec("carry_ffff_0_1", 16'hFFFF, 16'h0000, 1'b1, 17'h10000);
    drive_vec("carry_ffff_ffff_1", 16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF);
    drive_vec("overflow_8000", 16'h8000, 16'h8000, 1'b0, 17'h10000);
    drive_vec("mixed_cin", 16'h1234, 16'h4321, 1'b1, 17'h05556);
    run_cycles(2);
    chk("queue_drained", exp_q.size(), 32'd0);
    chk("pre_reset_value", {15'd0, carry_out, sum_out}, 32'h0000_5556);

    // Async reset while gated, mid low phase: no clock edge involved.
    CG = 1'b0;
    #5;
    reset_b = 1'b0;
    #1;
    chk("async_reset_clear", {15'd0, carry_out, sum_out}, 32'h0000_0000);
    @(negedge clk);
    reset_b = 1'b1;
    drive_vec("first_after_reset", 16'h0001, 16'h0002, 1'b0, 17'h00003);
    run_cycles(2);
    chk("final_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
